// File: rtl/debounce_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : debounce_sync
//  Purpose  : Conditions a noisy, asynchronous level input (push-button or
//             switch) into a clean, clock-synchronous level plus one-cycle
//             rise/fall pulses. A two-flop synchronizer feeds a four-state
//             stability FSM whose qualification counter advances only on
//             sample_en strobes.
//
//  Parameters
//    STABLE_CYCLES : qualified samples the synchronized input must hold
//                    before db_out changes (>= 2)
//    CNT_WIDTH     : qualification counter width (2**CNT_WIDTH >= STABLE_CYCLES)
//
//  Ports
//    clk        in   system clock, rising edge active
//    reset_n    in   asynchronous active-low reset
//    noisy_in   in   raw asynchronous level
//    sample_en  in   qualification strobe (tie to 1 to qualify every clock)
//    db_out     out  debounced level, registered
//    rise_pulse out  one-cycle pulse on db_out 0->1, registered
//    fall_pulse out  one-cycle pulse on db_out 1->0, registered
//
//  Revision : 1.0  initial release
// ============================================================================
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy_in,
    input  logic sample_en,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    // ------------------------------------------------------------------------
    // State encoding. Bit 1 mirrors the debounced level held in that state,
    // bit 0 marks a qualification in progress.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    // Terminal count: the qualifying strobe that arrives while the counter
    // sits here completes the qualification.
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_db;
    logic                 r_rise;
    logic                 r_fall;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_db_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;

    // Counter value on entering a WAIT state: the entry edge itself counts
    // as the first qualified sample when the strobe is present.
    logic [CNT_WIDTH-1:0] w_cnt_entry;
    // Qualification completes on this edge if the strobe is present.
    logic                 w_qualify_done;

    assign w_cnt_entry    = sample_en ? c_cnt_one : c_cnt_zero;
    assign w_qualify_done = sample_en && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // Two-flop synchronizer. Nothing sits between the flops so the first
    // stage has a full clock period to resolve metastability.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= noisy_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM state, counter and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_LOW;
            r_cnt   <= c_cnt_zero;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic.
    // In the WAIT states a reversal of r_sync2 is tested first, so it wins
    // over a qualification that would otherwise complete on the same edge.
    // Strobe-less edges fall through to the defaults and hold the counter.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_db;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            ST_LOW: begin
                w_db_nxt  = 1'b0;
                w_cnt_nxt = c_cnt_zero;
                if (r_sync2) begin
                    w_state_nxt = ST_WAIT_HIGH;
                    w_cnt_nxt   = w_cnt_entry;
                end
            end

            ST_WAIT_HIGH: begin
                if (!r_sync2) begin
                    // Glitch rejected, no pulse.
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (w_qualify_done) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = c_cnt_zero;
                    w_db_nxt    = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else if (sample_en) begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            ST_HIGH: begin
                w_db_nxt  = 1'b1;
                w_cnt_nxt = c_cnt_zero;
                if (!r_sync2) begin
                    w_state_nxt = ST_WAIT_LOW;
                    w_cnt_nxt   = w_cnt_entry;
                end
            end

            ST_WAIT_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (w_qualify_done) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = c_cnt_zero;
                    w_db_nxt    = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else if (sample_en) begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = c_cnt_zero;
                w_db_nxt    = 1'b0;
            end
        endcase
    end

    // Outputs come straight from flops.
    assign db_out     = r_db;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_sync
//  Purpose  : Self-checking bench for debounce_sync. A run-length reference
//             model predicts db_out and the pulses edge by edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_debounce_sync;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_WIDTH     = 3;
    localparam int LATENCY       = STABLE_CYCLES + 2;   // edges from raise to db change

    logic clk = 1'b0;
    logic reset_n;
    logic noisy_in;
    logic sample_en;
    logic db_out;
    logic rise_pulse;
    logic fall_pulse;

    debounce_sync #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .noisy_in   (noisy_in),
        .sample_en  (sample_en),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    // Downstream flop fed by the debounced level.
    logic dff_q = 1'b0;
    always @(posedge clk) dff_q <= db_out;

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------------
    // Reference model: input delayed two edges; a run of qualified samples
    // that disagree with the current level flips it after STABLE_CYCLES.
    // ------------------------------------------------------------------------
    bit m_s1, m_s2, m_db, m_rise, m_fall;
    int m_run;

    int  rise_cnt, fall_cnt, db_changes;
    bit  prev_rise, prev_fall, prev_db;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_rise = 0; m_fall = 0; m_run = 0;
        prev_rise = 0; prev_fall = 0; prev_db = 0;
    endtask

    task automatic model_edge();
        bit s;
        s      = m_s2;
        m_rise = 0;
        m_fall = 0;
        if (s == m_db) begin
            m_run = 0;
        end else if (sample_en) begin
            m_run++;
            if (m_run == STABLE_CYCLES) begin
                m_db   = s;
                m_rise = s;
                m_fall = !s;
                m_run  = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = noisy_in;
    endtask

    // One clock: drive on the falling edge, model on the rising edge,
    // compare shortly after it.
    task automatic step(input logic nin, input logic en);
        @(negedge clk);
        noisy_in  = nin;
        sample_en = en;
        @(posedge clk);
        model_edge();
        #1;
        check("db_out",     32'(db_out),     32'(m_db));
        check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        check("pulse_excl", 32'(rise_pulse & fall_pulse), 32'd0);
        check("pulse_width", 32'((rise_pulse & prev_rise) | (fall_pulse & prev_fall)), 32'd0);
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        if (db_out != prev_db) db_changes++;
        prev_rise = rise_pulse;
        prev_fall = fall_pulse;
        prev_db   = db_out;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_db_out", 32'(db_out),     32'd0);
        check("rst_rise",   32'(rise_pulse), 32'd0);
        check("rst_fall",   32'(fall_pulse), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Raise the input and count edges until db_out goes high (bounded).
    task automatic rise_latency(output int edges);
        edges = -1;
        for (int i = 1; i <= 3 * LATENCY; i++) begin
            step(1'b1, 1'b1);
            if (db_out && edges < 0) edges = i;
        end
    endtask

    int lat, r0, f0, c0, rise_idx;
    bit dff_saw1, dff_saw0_after;

    initial begin
        reset_n   = 1'b0;
        noisy_in  = 1'b0;
        sample_en = 1'b0;
        rise_cnt  = 0;
        fall_cnt  = 0;
        db_changes = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_db_out", 32'(db_out),     32'd0);
        check("reset_rise",   32'(rise_pulse), 32'd0);
        check("reset_fall",   32'(fall_pulse), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Glitch reject: 3 clocks high while low.
        r0 = rise_cnt;
        repeat (4) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        check("glitch_no_rise", 32'(rise_cnt - r0), 32'd0);
        check("glitch_db_low",  32'(db_out),        32'd0);

        // Clean rise: full latency proves the counter restarted from 0.
        r0 = rise_cnt; f0 = fall_cnt;
        rise_latency(lat);
        check("clean_rise_latency", 32'(lat), 32'(LATENCY));
        check("clean_rise_pulses",  32'(rise_cnt - r0), 32'd1);
        check("clean_no_fall",      32'(fall_cnt - f0), 32'd0);

        // Bounce then settle.
        repeat (10) step(1'b0, 1'b1);
        r0 = rise_cnt; c0 = db_changes;
        begin
            logic lvl;
            lvl = 1'b0;
            for (int t = 0; t < 6; t++) begin
                lvl = ~lvl;
                repeat ($urandom_range(1, 3)) step(lvl, 1'b1);
            end
        end
        rise_latency(lat);
        check("bounce_latency",    32'(lat),              32'(LATENCY));
        check("bounce_one_rise",   32'(rise_cnt - r0),    32'd1);
        check("bounce_one_change", 32'(db_changes - c0),  32'd1);

        // Reset mid-count in WAIT_LOW with counter at 3.
        check("pre_reset_db", 32'(db_out), 32'd1);
        for (int i = 0; i < 2 * LATENCY && m_run != 3; i++) step(1'b0, 1'b1);
        check("pre_reset_db_held", 32'(db_out), 32'd1);
        async_reset();
        rise_latency(lat);
        check("post_reset_latency", 32'(lat), 32'(LATENCY));

        // Strobed qualification: strobe every 4th clock.
        repeat (10) step(1'b0, 1'b1);
        rise_idx = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, (i % 4) == 3);
            if (db_out && rise_idx < 0) rise_idx = i;
        end
        check("strobe_rise_step", 32'(rise_idx), 32'd15);

        // Round trip with downstream flop.
        repeat (10) step(1'b0, 1'b1);
        r0 = rise_cnt; f0 = fall_cnt;
        dff_saw1 = 0; dff_saw0_after = 0;
        for (int i = 0; i < LATENCY + 20; i++) begin
            step(1'b1, 1'b1);
            if (dff_q) dff_saw1 = 1;
        end
        for (int i = 0; i < LATENCY + 4; i++) begin
            step(1'b0, 1'b1);
            if (dff_saw1 && !dff_q) dff_saw0_after = 1;
        end
        check("trip_rise_count", 32'(rise_cnt - r0), 32'd1);
        check("trip_fall_count", 32'(fall_cnt - f0), 32'd1);
        check("trip_dff_got1",   32'(dff_saw1),       32'd1);
        check("trip_dff_got0",   32'(dff_saw0_after), 32'd1);

        // Randomized runs with random strobes and occasional resets.
        for (int r = 0; r < 250; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) step(lvl, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/debounce_sync.md
# debounce_sync

Conditions a noisy, asynchronous level input (push-button or switch) into a clean, clock-synchronous level plus single-cycle edge pulses. Sits directly upstream of the D flip-flop stages and drives their `d` input, so downstream flops only ever see a settled signal that meets setup and hold. It uses a two-flop synchronizer followed by a four-state stability FSM with a qualification counter.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive qualified samples the synchronized input must hold before the output changes. Legal range is 2 or more.
- `CNT_WIDTH`, default 3: width of the qualification counter. Must satisfy `2**CNT_WIDTH >= STABLE_CYCLES`.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset; deassertion is synchronous to `clk` at system level.
- `noisy_in`  input  1  raw asynchronous level.
- `sample_en`  input  1  qualification strobe; the counter advances only when it is 1. Tie it to 1 to qualify every clock.
- `db_out`  output  1  debounced level, registered.
- `rise_pulse`  output  1  one-cycle pulse on a 0→1 change of `db_out`, registered.
- `fall_pulse`  output  1  one-cycle pulse on a 1→0 change of `db_out`, registered.

## Operation
- **Synchronizer:** `noisy_in` → `sync1` → `sync2`. There is no logic between the two flops. The FSM reads only `sync2`.
- **FSM states:** `LOW` (db_out = 0), `WAIT_HIGH` (db_out = 0), `HIGH` (db_out = 1), `WAIT_LOW` (db_out = 1).
- **LOW:**
  - If `sync2` = 1, go to `WAIT_HIGH`. The counter becomes 1 if `sample_en` is 1, otherwise 0.
  - Otherwise stay in `LOW` with the counter at 0.
- **WAIT_HIGH:**
  - If `sync2` = 0, return to `LOW` and clear the counter. The glitch is rejected and no pulse is issued.
  - Else, if `sample_en` = 1 and counter = `STABLE_CYCLES`-1: go to `HIGH`, set db_out to 1, assert `rise_pulse` for one cycle, and clear the counter.
  - Else, if `sample_en` = 1, increment the counter.
  - Else, hold the counter.
- **HIGH / WAIT_LOW:** mirror of `LOW` / `WAIT_HIGH` with the polarities inverted. A completed qualification sets db_out to 0 and pulses `fall_pulse`.
- **Counter:** it never exceeds `STABLE_CYCLES`-1 and never wraps. It is always 0 in `LOW` and `HIGH`.
- **Pulse exclusivity:** `rise_pulse` and `fall_pulse` are never both 1 in the same cycle. Neither is ever high for two consecutive cycles.
- **Simultaneous events:** a `sync2` reversal in a WAIT state takes priority over qualification, even when counter = `STABLE_CYCLES`-1 and `sample_en` = 1.
- **Reset:** all flops clear immediately and asynchronously, including mid-qualification.
  - After reset: `sync1` = `sync2` = 0, state `LOW`, counter 0, `db_out` = 0, `rise_pulse` = 0, `fall_pulse` = 0.
  - Any partial count is discarded.

## Timing
- The synchronizer adds 2 cycles of latency. A level that is stable at `noisy_in` before rising edge N appears on `sync2` after edge N+1.
- With `sample_en` tied to 1 and `noisy_in` held stable, `db_out` and the matching pulse change after edge N+1+`STABLE_CYCLES`.
  - For the default of 4, that is after edge N+5.
- The pulse is high for exactly the first cycle in which the new `db_out` value is visible.
- With a strobed `sample_en`, qualification needs `STABLE_CYCLES` edges with `sample_en` = 1 while `sync2` holds. Edges with `sample_en` = 0 neither count nor clear.
- A `noisy_in` excursion that reaches `sync2` for fewer than `STABLE_CYCLES` qualified edges produces no output change and no pulse.
- Outputs are direct flop outputs, with no combinational path from any input to any output.

## Test plan
- **Clean rise:** defaults, `sample_en` = 1, reset released, `noisy_in` raised before edge 10 and held.
  - Required: `db_out` rises after edge 15.
  - Required: `rise_pulse` = 1 for exactly the cycle after edge 15.
  - Required: `fall_pulse` stays 0.
- **Glitch reject:** `noisy_in` high for 3 clocks, then low.
  - Required: `db_out` stays 0, both pulses stay 0, and the FSM returns to `LOW` with the counter at 0.
- **Bounce then settle:** toggle `noisy_in` at random 1–3 clock intervals 6 times, then hold it at 1.
  - Required: exactly one `rise_pulse`.
  - Required: `db_out` = 1 exactly 5 edges after the last toggle is sampled, with no intermediate `db_out` changes.
- **Reset mid-count:** in `WAIT_LOW` with counter = 3, assert `reset_n` = 0 between clock edges.
  - Required: `db_out` = 0 immediately, without waiting for a clock edge, and both pulses = 0.
  - Required: after release with `noisy_in` = 1, a full 5-edge qualification is needed again.
- **Strobed qualification:** `sample_en` high every 4th clock, `noisy_in` raised and held.
  - Required: `db_out` rises only after the 4th qualified strobe following `sync2` = 1.
  - Required: the counter holds its value between strobes.
- **Round trip:** rise, hold for 20 clocks, then fall.
  - Required: one `rise_pulse` and one `fall_pulse`, each 1 cycle wide, never overlapping.
  - Required: a downstream DFF fed by `db_out` captures 1 and then 0.
